// File: rtl/rvfi_mem_responder.sv
// rvfi_mem_responder: imem/dmem responder over a shared word store with wait-state
// injection, byte-strobed writes, abort on request drop and out-of-range error pulses.
module rvfi_mem_chan #(
    parameter int MAX_WAIT = 3,
    parameter int WAIT_W   = 2
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              req_i,
    input  logic [WAIT_W-1:0] wait_i,
    output logic              resp_o,
    output logic              enter_o
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;
    localparam logic [WAIT_W-1:0] MAXW = WAIT_W'(MAX_WAIT);
    state_e            state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d, wsat;
    assign wsat    = ({{(32-WAIT_W){1'b0}}, wait_i} > 32'(MAX_WAIT)) ? MAXW : wait_i;
    assign resp_o  = state_q == S_RESP;
    assign enter_o = state_d == S_RESP;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: if (req_i) begin
                cnt_d   = wsat;
                state_d = wsat == '0 ? S_RESP : S_WAIT;
            end
            S_WAIT: if (!req_i) begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end else if (cnt_q == WAIT_W'(1)) begin
                state_d = S_RESP;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

module rvfi_mem_responder #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 256,
    parameter int MAX_WAIT = 3,
    localparam int WAIT_W  = $clog2(MAX_WAIT + 1),
    localparam int STRB_W  = DATA_W / 8
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              imem_req_i,
    input  logic [ADDR_W-1:0] imem_addr_i,
    input  logic [WAIT_W-1:0] imem_wait_i,
    output logic              imem_ready_o,
    output logic [DATA_W-1:0] imem_rdata_o,
    input  logic              dmem_req_i,
    input  logic [ADDR_W-1:0] dmem_addr_i,
    input  logic [DATA_W-1:0] dmem_wdata_i,
    input  logic [STRB_W-1:0] dmem_wstrb_i,
    input  logic [WAIT_W-1:0] dmem_wait_i,
    output logic              dmem_ready_o,
    output logic [DATA_W-1:0] dmem_rdata_o,
    output logic              err_o
);
    localparam int OFF   = $clog2(STRB_W);
    localparam int IDX_W = $clog2(DEPTH);
    logic              i_resp, i_enter, d_resp, d_enter, i_oob, d_oob, d_wr;
    logic [IDX_W-1:0]  i_idx, d_idx;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] i_word, imem_rdata_q, imem_rdata_d, dmem_rdata_q, dmem_rdata_d;
    logic              unused_addr;
    rvfi_mem_chan #(.MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)) u_ichan (
        .clock_i(clock_i), .reset_i(reset_i), .req_i(imem_req_i), .wait_i(imem_wait_i),
        .resp_o(i_resp), .enter_o(i_enter)
    );
    rvfi_mem_chan #(.MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)) u_dchan (
        .clock_i(clock_i), .reset_i(reset_i), .req_i(dmem_req_i), .wait_i(dmem_wait_i),
        .resp_o(d_resp), .enter_o(d_enter)
    );
    assign unused_addr  = ^{imem_addr_i, dmem_addr_i};
    assign i_idx        = imem_addr_i[OFF +: IDX_W];
    assign d_idx        = dmem_addr_i[OFF +: IDX_W];
    assign i_oob        = |imem_addr_i[ADDR_W-1:OFF+IDX_W];
    assign d_oob        = |dmem_addr_i[ADDR_W-1:OFF+IDX_W];
    assign d_wr         = d_resp && |dmem_wstrb_i && !d_oob;
    assign imem_ready_o = i_resp;
    assign dmem_ready_o = d_resp;
    assign imem_rdata_o = imem_rdata_q;
    assign dmem_rdata_o = dmem_rdata_q;
    assign err_o        = (i_resp && i_oob) || (d_resp && d_oob);
    // A fetch entering RESP on the edge that commits a write must see the new bytes.
    always_comb begin
        i_word = mem_q[i_idx];
        for (int b = 0; b < STRB_W; b++)
            if (d_wr && dmem_wstrb_i[b] && i_idx == d_idx) i_word[8*b +: 8] = dmem_wdata_i[8*b +: 8];
        imem_rdata_d = i_enter ? (i_oob ? '0 : i_word) : imem_rdata_q;
        dmem_rdata_d = d_enter ? (d_oob ? '0 : mem_q[d_idx]) : dmem_rdata_q;
    end
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            imem_rdata_q <= '0;
            dmem_rdata_q <= '0;
            for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
        end else begin
            imem_rdata_q <= imem_rdata_d;
            dmem_rdata_q <= dmem_rdata_d;
            if (d_wr)
                for (int b = 0; b < STRB_W; b++)
                    if (dmem_wstrb_i[b]) mem_q[d_idx][8*b +: 8] <= dmem_wdata_i[8*b +: 8];
        end
    end
endmodule

// File: tb/tb_rvfi_mem_responder.sv
// tb_rvfi_mem_responder: directed and randomized checks of the memory responder against
// a transaction-level model (due-cycle timestamps and a plain word array).
module tb_rvfi_mem_responder;
    localparam int DEPTH = 256;
    localparam int MAXW  = 3;
    logic        clk = 0, rst = 1;
    logic        imem_req_i = 0, dmem_req_i = 0;
    logic [31:0] imem_addr_i = 0, dmem_addr_i = 0, dmem_wdata_i = 0;
    logic [1:0]  imem_wait_i = 0, dmem_wait_i = 0;
    logic [3:0]  dmem_wstrb_i = 0;
    logic        imem_ready_o, dmem_ready_o, err_o;
    logic [31:0] imem_rdata_o, dmem_rdata_o;
    int          checks = 0, fails = 0, cyc = 0;
    logic [31:0] mem_m [DEPTH];

    always #5 clk = ~clk;

    rvfi_mem_responder dut (
        .clock_i(clk), .reset_i(rst),
        .imem_req_i(imem_req_i), .imem_addr_i(imem_addr_i), .imem_wait_i(imem_wait_i),
        .imem_ready_o(imem_ready_o), .imem_rdata_o(imem_rdata_o),
        .dmem_req_i(dmem_req_i), .dmem_addr_i(dmem_addr_i), .dmem_wdata_i(dmem_wdata_i),
        .dmem_wstrb_i(dmem_wstrb_i), .dmem_wait_i(dmem_wait_i),
        .dmem_ready_o(dmem_ready_o), .dmem_rdata_o(dmem_rdata_o), .err_o(err_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: each channel is either free or busy until a due cycle = accept + 1 + min(wait,MAX).
    initial begin
        bit          bi, bd, ri, rd;
        int          due_i, due_d, wi, wd;
        int unsigned ia, da;
        logic [31:0] xi, xd;
        bi = 0; bd = 0; due_i = 0; due_d = 0; xi = 0; xd = 0;
        for (int k = 0; k < DEPTH; k++) mem_m[k] = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bi = 0; bd = 0; xi = 0; xd = 0;
                for (int k = 0; k < DEPTH; k++) mem_m[k] = 0;
                chk("rst_iready", 32'(imem_ready_o), 0);
                chk("rst_dready", 32'(dmem_ready_o), 0);
                chk("rst_err", 32'(err_o), 0);
                chk("rst_irdata", imem_rdata_o, 0);
                chk("rst_drdata", dmem_rdata_o, 0);
            end else begin
                ia = 32'(imem_addr_i >> 2);
                da = 32'(dmem_addr_i >> 2);
                ri = bi && cyc == due_i;
                rd = bd && cyc == due_d;
                if (ri) xi = ia < DEPTH ? mem_m[ia] : 0;
                if (rd) xd = da < DEPTH ? mem_m[da] : 0;
                chk("m_iready", 32'(imem_ready_o), 32'(ri));
                chk("m_dready", 32'(dmem_ready_o), 32'(rd));
                chk("m_err", 32'(err_o), 32'((ri && ia >= DEPTH) || (rd && da >= DEPTH)));
                chk("m_irdata", imem_rdata_o, xi);
                chk("m_drdata", dmem_rdata_o, xd);
                if (rd && da < DEPTH)
                    for (int b = 0; b < 4; b++)
                        if (dmem_wstrb_i[b]) mem_m[da][8*b +: 8] = dmem_wdata_i[8*b +: 8];
                wi = int'(imem_wait_i);
                wd = int'(dmem_wait_i);
                if (ri || (bi && !imem_req_i)) bi = 0;
                else if (!bi && imem_req_i) begin bi = 1; due_i = cyc + 1 + (wi > MAXW ? MAXW : wi); end
                if (rd || (bd && !dmem_req_i)) bd = 0;
                else if (!bd && dmem_req_i) begin bd = 1; due_d = cyc + 1 + (wd > MAXW ? MAXW : wd); end
            end
            cyc++;
        end
    end

    task automatic dtx(input logic [31:0] a, input logic [31:0] wdat, input logic [3:0] st,
                       input int w, output logic [31:0] r, output logic e, output int lat);
        @(posedge clk); #1;
        dmem_req_i = 1; dmem_addr_i = a; dmem_wdata_i = wdat; dmem_wstrb_i = st; dmem_wait_i = 2'(w);
        lat = 0; r = 0; e = 0;
        forever begin
            @(negedge clk);
            if (dmem_ready_o) break;
            lat++;
            if (lat > 20) begin
                checks++; fails++;
                $display("FAIL d_timeout: got no dmem_ready expected one within 20 cycles");
                break;
            end
        end
        r = dmem_rdata_o; e = err_o;
        @(posedge clk); #1;
        dmem_req_i = 0;
    endtask

    task automatic itx(input logic [31:0] a, input int w, output logic [31:0] r, output logic e,
                       output int lat);
        @(posedge clk); #1;
        imem_req_i = 1; imem_addr_i = a; imem_wait_i = 2'(w);
        lat = 0; r = 0; e = 0;
        forever begin
            @(negedge clk);
            if (imem_ready_o) break;
            lat++;
            if (lat > 20) begin
                checks++; fails++;
                $display("FAIL i_timeout: got no imem_ready expected one within 20 cycles");
                break;
            end
        end
        r = imem_rdata_o; e = err_o;
        @(posedge clk); #1;
        imem_req_i = 0;
    endtask

    function automatic logic [31:0] raddr();
        int          r;
        logic [31:0] lo;
        r  = $urandom_range(0, 9);
        lo = 32'($urandom_range(0, 3));
        if (r < 8) return 32'h40 + 32'(r) * 4 + lo;
        if (r == 8) return 32'h400 + lo;
        return $urandom | 32'h400;
    endfunction

    initial begin
        logic [31:0] r, r2;
        logic        e, e2;
        int          lat, lat2, n;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_irdata", imem_rdata_o, 0);
        chk("reset_dready", 32'(dmem_ready_o), 0);
        rst = 0;
        // basic write then fetch
        dtx(32'h10, 32'hDEADBEEF, 4'hF, 0, r, e, lat);
        chk("t1_dlat", 32'(lat), 1);
        chk("t1_derr", 32'(e), 0);
        itx(32'h10, 0, r, e, lat);
        chk("t1_irdata", r, 32'hDEADBEEF);
        chk("t1_ilat", 32'(lat), 1);
        @(negedge clk);
        chk("t1_ipulse", 32'(imem_ready_o), 0);
        // wait states
        dtx(32'h10, 0, 4'h0, 2, r, e, lat);
        chk("t2_lat2", 32'(lat), 3);
        chk("t2_rd", r, 32'hDEADBEEF);
        dtx(32'h10, 0, 4'h0, 3, r, e, lat);
        chk("t2_lat3", 32'(lat), 4);
        // byte strobes
        dtx(32'h20, 32'h11223344, 4'hF, 0, r, e, lat);
        dtx(32'h20, 32'hAABBCCDD, 4'h5, 1, r, e, lat);
        chk("t3_prewrite", r, 32'h11223344);
        dtx(32'h20, 0, 4'h0, 0, r, e, lat);
        chk("t3_merge", r, 32'h11BB33DD);
        // abort in the second wait cycle
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            dmem_req_i = i < 2; dmem_addr_i = 32'h30; dmem_wdata_i = 32'h12345678;
            dmem_wstrb_i = 4'hF; dmem_wait_i = 2'd3;
            @(negedge clk);
            n += int'(dmem_ready_o);
        end
        chk("t4_noready", 32'(n), 0);
        dtx(32'h30, 0, 4'h0, 0, r, e, lat);
        chk("t4_unchanged", r, 0);
        chk("t4_idle_lat", 32'(lat), 1);
        // out of range
        dtx(32'h400, 0, 4'h0, 0, r, e, lat);
        chk("t5_oob_rerr", 32'(e), 1);
        chk("t5_oob_rdata", r, 0);
        dtx(32'h400, 32'hFFFFFFFF, 4'hF, 0, r, e, lat);
        chk("t5_oob_werr", 32'(e), 1);
        itx(32'h0, 0, r, e, lat);
        chk("t5_alias_clean", r, 0);
        chk("t5_inrange_err", 32'(e), 0);
        // same-word collision, then fetch forwarded from a just-committed write
        fork
            itx(32'h10, 0, r, e, lat);
            dtx(32'h10, 32'h55555555, 4'hF, 0, r2, e2, lat2);
        join
        chk("t5_coll_old", r, 32'hDEADBEEF);
        itx(32'h10, 0, r, e, lat);
        chk("t5_coll_new", r, 32'h55555555);
        fork
            itx(32'h14, 1, r, e, lat);
            dtx(32'h14, 32'hCAFEF00D, 4'hF, 0, r2, e2, lat2);
        join
        chk("t5_fwd", r, 32'hCAFEF00D);
        chk("t5_fwd_lat", 32'(lat), 2);
        // randomized traffic, checked every cycle by the model
        fork
            begin
                bit seen;
                for (int i = 0; i < 2000; i++) begin
                    @(negedge clk); seen = imem_ready_o;
                    @(posedge clk); #1;
                    if (!imem_req_i || seen) begin
                        imem_req_i = 1'($urandom_range(0, 1));
                        imem_addr_i = raddr(); imem_wait_i = 2'($urandom_range(0, 3));
                    end else if ($urandom_range(0, 15) == 0) imem_req_i = 0;
                end
            end
            begin
                bit seen;
                for (int i = 0; i < 2000; i++) begin
                    @(negedge clk); seen = dmem_ready_o;
                    @(posedge clk); #1;
                    if (!dmem_req_i || seen) begin
                        dmem_req_i = 1'($urandom_range(0, 1));
                        dmem_addr_i = raddr(); dmem_wdata_i = $urandom;
                        dmem_wstrb_i = $urandom_range(0, 2) == 0 ? 4'h0 : 4'($urandom_range(1, 15));
                        dmem_wait_i = 2'($urandom_range(0, 3));
                    end else if ($urandom_range(0, 15) == 0) dmem_req_i = 0;
                end
            end
        join
        @(posedge clk); #1;
        imem_req_i = 0; dmem_req_i = 0;
        repeat (2) @(posedge clk);
        // reset mid-wait on both channels
        dtx(32'h18, 32'h0BADF00D, 4'hF, 0, r, e, lat);
        itx(32'h18, 0, r, e, lat);
        chk("t6_pre", r, 32'h0BADF00D);
        @(posedge clk); #1;
        imem_req_i = 1; imem_addr_i = 32'h18; imem_wait_i = 2'd3;
        dmem_req_i = 1; dmem_addr_i = 32'h18; dmem_wdata_i = 32'hFFFFFFFF; dmem_wstrb_i = 4'hF;
        dmem_wait_i = 2'd3;
        @(posedge clk); #3;
        rst = 1;
        #1;
        chk("t6_iready", 32'(imem_ready_o), 0);
        chk("t6_dready", 32'(dmem_ready_o), 0);
        chk("t6_err", 32'(err_o), 0);
        chk("t6_irdata", imem_rdata_o, 0);
        @(posedge clk); #1;
        rst = 0; imem_req_i = 0; dmem_req_i = 0;
        itx(32'h18, 0, r, e, lat);
        chk("t6_cleared", r, 0);
        chk("t6_ilat", 32'(lat), 1);
        dtx(32'h20, 0, 4'h0, 0, r, e, lat);
        chk("t6_cleared2", r, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
